// File: rtl/mem_loader_if.sv
// Input word stream and shared memory write port of the memory loader.
interface mem_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              rw;

    // Loader side: consumes the input stream, drives the memory port.
    modport master (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_we, rw
    );

    // Producer / memory side.
    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_we, rw
    );
endinterface

// File: rtl/mem_loader.sv
// Write-side loader: fills N_WORDS consecutive memory words from a
// valid/ready stream, then pulses done for the read-side accumulator.
module mem_loader #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int N_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    mem_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [2:0]        ps
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_INC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Pre-increment count value of the final word of a load.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(N_WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic in_ready_c;
    logic mem_we_c;
    logic rw_c;
    logic busy_c;
    logic done_c;

    // State, address counter, word counter and write-data latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, datapath updates and Moore output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        in_ready_c = 1'b0;
        mem_we_c   = 1'b0;
        rw_c       = 1'b1;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_ARM;
            end
            S_ARM: begin
                busy_c  = 1'b1;
                addr_d  = '0;
                count_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy_c     = 1'b1;
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    wdata_d = bus.in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_c   = 1'b1;
                mem_we_c = 1'b1;
                rw_c     = 1'b0;
                state_d  = S_INC;
            end
            S_INC: begin
                busy_c  = 1'b1;
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = (count_q == LAST_CNT) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            // Unused encodings behave as IDLE and recover to it.
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = mem_we_c;
    assign bus.rw        = rw_c;
    assign busy          = busy_c;
    assign done          = done_c;
    assign count         = count_q;
    assign ps            = state_q;
endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: one instance with N_WORDS=4 and one
// with N_WORDS=16; a monitor checks every write and done pulse.
module tb_mem_loader;
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        int         edge_n;   // -1: timing not checked
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [1:0] go_a  = '0;
    logic [1:0] vld_a = '0;
    logic [7:0] din_a [2];

    logic busy4, done4, busy16, done16;
    logic [4:0] count4, count16;
    logic [2:0] ps4, ps16;

    mem_loader_if #(.DATA_W(8), .ADDR_W(4)) if4 ();
    mem_loader_if #(.DATA_W(8), .ADDR_W(4)) if16 ();

    assign if4.in_data   = din_a[0];
    assign if4.in_valid  = vld_a[0];
    assign if16.in_data  = din_a[1];
    assign if16.in_valid = vld_a[1];

    mem_loader #(.DATA_W(8), .ADDR_W(4), .N_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .go(go_a[0]), .bus(if4),
        .busy(busy4), .done(done4), .count(count4), .ps(ps4)
    );
    mem_loader #(.DATA_W(8), .ADDR_W(4), .N_WORDS(16)) dut16 (
        .clk(clk), .rst(rst), .go(go_a[1]), .bus(if16),
        .busy(busy16), .done(done16), .count(count16), .ps(ps16)
    );

    logic [1:0] we_a, rw_a, done_a, busy_a, rdy_a;
    logic [3:0] addr_a  [2];
    logic [7:0] wdata_a [2];
    logic [4:0] count_a [2];
    logic [2:0] ps_a    [2];
    assign we_a       = {if16.mem_we, if4.mem_we};
    assign rw_a       = {if16.rw, if4.rw};
    assign rdy_a      = {if16.in_ready, if4.in_ready};
    assign done_a     = {done16, done4};
    assign busy_a     = {busy16, busy4};
    assign addr_a[0]  = if4.mem_addr;
    assign addr_a[1]  = if16.mem_addr;
    assign wdata_a[0] = if4.mem_wdata;
    assign wdata_a[1] = if16.mem_wdata;
    assign count_a[0] = count4;
    assign count_a[1] = count16;
    assign ps_a[0]    = ps4;
    assign ps_a[1]    = ps16;

    wr_t exp_wr   [2][$];
    int  exp_done [2][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wr_t mk(input int a, input int d, input int e);
        wr_t w;
        w.addr   = 4'(a);
        w.data   = 8'(d);
        w.edge_n = e;
        return w;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every write strobe and done pulse must match the next expectation.
    wr_t mw;
    int  md;
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (we_a[i]) begin
                if (exp_wr[i].size() == 0) begin
                    chk("spurious_we", 32'd1, 32'd0);
                end else begin
                    mw = exp_wr[i].pop_front();
                    chk("wr_addr", 32'(addr_a[i]), 32'(mw.addr));
                    chk("wr_data", 32'(wdata_a[i]), 32'(mw.data));
                    chk("wr_rw", 32'(rw_a[i]), 32'd0);
                    if (mw.edge_n >= 0) chk("wr_edge", cyc, mw.edge_n);
                end
            end else begin
                chk("rw_idle_high", 32'(rw_a[i]), 32'd1);
            end
            if (done_a[i]) begin
                if (exp_done[i].size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    md = exp_done[i].pop_front();
                    if (md >= 0) chk("done_edge", cyc, md);
                    chk("done_count", 32'(count_a[i]), (i == 0) ? 32'd4 : 32'd16);
                end
            end
        end
    end

    // Offer one word and return at the negedge after it is accepted.
    task automatic sendw(input int i, input logic [7:0] d);
        bit ok = 1'b0;
        din_a[i] = d;
        vld_a[i] = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (rdy_a[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Return at the negedge where done is high.
    task automatic wait_done(input int i);
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (done_a[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int e0;
        din_a[0] = '0;
        din_a[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset with go low.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("rst_ps", 32'(ps_a[i]), 32'd0);
                chk("rst_ready", 32'(rdy_a[i]), 32'd0);
                chk("rst_we", 32'(we_a[i]), 32'd0);
                chk("rst_rw", 32'(rw_a[i]), 32'd1);
                chk("rst_busy", 32'(busy_a[i]), 32'd0);
                chk("rst_done", 32'(done_a[i]), 32'd0);
                chk("rst_count", 32'(count_a[i]), 32'd0);
                chk("rst_addr", 32'(addr_a[i]), 32'd0);
                chk("rst_wdata", 32'(wdata_a[i]), 32'd0);
            end
        end

        // Basic 4-word load with exact cycle timing.
        go_a[0] = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) exp_wr[0].push_back(mk(k, 8'hA0 + k, e0 + 2 + 3*k));
        exp_done[0].push_back(e0 + 13);
        @(negedge clk);
        go_a[0] = 1'b0;
        for (int k = 0; k < 4; k++) sendw(0, 8'(8'hA0 + k));
        vld_a[0] = 1'b0;
        wait_done(0);
        @(negedge clk);
        chk("a_count", 32'(count_a[0]), 32'd4);
        chk("a_addr", 32'(addr_a[0]), 32'd4);
        chk("a_ps", 32'(ps_a[0]), 32'd0);
        chk("a_done_gone", 32'(done_a[0]), 32'd0);

        // Backpressure before the second word.
        go_a[0] = 1'b1;
        @(negedge clk);
        go_a[0] = 1'b0;
        exp_wr[0].push_back(mk(0, 8'hB0, -1));
        sendw(0, 8'hB0);
        vld_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("bp_ps", 32'(ps_a[0]), 32'd2);
            chk("bp_ready", 32'(rdy_a[0]), 32'd1);
            chk("bp_addr", 32'(addr_a[0]), 32'd1);
            chk("bp_count", 32'(count_a[0]), 32'd1);
            @(negedge clk);
        end
        for (int k = 1; k < 4; k++) exp_wr[0].push_back(mk(k, 8'hB0 + k, -1));
        exp_done[0].push_back(-1);
        for (int k = 1; k < 4; k++) sendw(0, 8'(8'hB0 + k));
        vld_a[0] = 1'b0;
        wait_done(0);
        @(negedge clk);
        chk("b_count", 32'(count_a[0]), 32'd4);

        // go held high for a whole load and through DONE.
        go_a[0] = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) exp_wr[0].push_back(mk(k, 8'hC0 + k, e0 + 2 + 3*k));
        exp_done[0].push_back(e0 + 13);
        @(negedge clk);
        for (int k = 0; k < 4; k++) sendw(0, 8'(8'hC0 + k));
        vld_a[0] = 1'b0;
        wait_done(0);
        @(negedge clk);
        chk("c_idle", 32'(ps_a[0]), 32'd0);
        @(negedge clk);
        chk("c_rearm", 32'(ps_a[0]), 32'd1);
        go_a[0] = 1'b0;
        exp_wr[0].push_back(mk(0, 8'hD0, -1));
        exp_wr[0].push_back(mk(1, 8'hD1, -1));
        sendw(0, 8'hD0);
        sendw(0, 8'hD1);
        repeat (2) @(negedge clk);
        chk("r_pre_count", 32'(count_a[0]), 32'd2);
        chk("r_pre_addr", 32'(addr_a[0]), 32'd2);

        // Asynchronous reset in mid-cycle while a third word is offered.
        din_a[0] = 8'hD2;
        vld_a[0] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("r_ps", 32'(ps4), 32'd0);
        chk("r_addr", 32'(if4.mem_addr), 32'd0);
        chk("r_count", 32'(count4), 32'd0);
        chk("r_we", 32'(if4.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("r_hold_ps", 32'(ps_a[0]), 32'd0);
            chk("r_hold_ready", 32'(rdy_a[0]), 32'd0);
        end
        vld_a[0] = 1'b0;

        // Full 16-word load: address wraps, count reaches 16.
        go_a[1] = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 16; k++) exp_wr[1].push_back(mk(k, 8'h30 + k, e0 + 2 + 3*k));
        exp_done[1].push_back(e0 + 49);
        @(negedge clk);
        go_a[1] = 1'b0;
        for (int k = 0; k < 16; k++) sendw(1, 8'(8'h30 + k));
        vld_a[1] = 1'b0;
        wait_done(1);
        @(negedge clk);
        chk("f_count", 32'(count_a[1]), 32'd16);
        chk("f_addr", 32'(addr_a[1]), 32'd0);
        chk("f_ps", 32'(ps_a[1]), 32'd0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("pending_writes", 32'(exp_wr[i].size()), 32'd0);
            chk("pending_done", 32'(exp_done[i].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
